// File: rtl/adder_byte_sequencer_pkg.sv
// Shared types and constants for the byte-serial front/back end of the 16-bit adder.
package adder_byte_sequencer_pkg;

    typedef enum logic [2:0] {
        LOAD,
        ISSUE,
        SEND_LO,
        SEND_HI,
        RELEASE
    } state_t;

    localparam int BYTES_PER_OP        = 4;
    localparam int DEFAULT_ADD_TIMEOUT = 64;

endpackage

// File: rtl/adder_byte_sequencer_if.sv
// Byte input stream, adder handshake and byte output stream bundled together.
interface adder_byte_sequencer_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_cin;
    logic        in_ready;

    logic        add_en;
    logic [15:0] add_A;
    logic [15:0] add_B;
    logic        add_cin;
    logic        add_ready;
    logic [15:0] add_sum;
    logic        add_cout;

    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_cout;
    logic        out_ready;
    logic        err_timeout;

    modport master (
        input  in_valid, in_data, in_cin, add_ready, add_sum, add_cout, out_ready,
        output in_ready, add_en, add_A, add_B, add_cin,
               out_valid, out_data, out_last, out_cout, err_timeout
    );

    modport slave (
        output in_valid, in_data, in_cin, add_ready, add_sum, add_cout, out_ready,
        input  in_ready, add_en, add_A, add_B, add_cin,
               out_valid, out_data, out_last, out_cout, err_timeout
    );

endinterface

// File: rtl/adder_byte_sequencer_operand_assembler.sv
// Collects A_lo, A_hi, B_lo, B_hi into operand registers; carry-in is latched with B_hi.
module adder_byte_sequencer_operand_assembler
    import adder_byte_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clr,
    input  logic [7:0]  data,
    input  logic        cin,
    output logic        full,
    output logic [15:0] add_A,
    output logic [15:0] add_B,
    output logic        add_cin
);

    logic [1:0]      byte_cnt;
    logic [3:0][7:0] bytes;
    logic            cin_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            bytes    <= '0;
            cin_q    <= 1'b0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (load) begin
            bytes[byte_cnt] <= data;
            byte_cnt        <= byte_cnt + 2'd1;
            if (byte_cnt == 2'(BYTES_PER_OP - 1))
                cin_q <= cin;
        end
    end

    // Counter wraps to 0 on the last byte, so the next operation starts clean.
    assign full    = load && (byte_cnt == 2'(BYTES_PER_OP - 1));
    assign add_A   = {bytes[1], bytes[0]};
    assign add_B   = {bytes[3], bytes[2]};
    assign add_cin = cin_q;

endmodule

// File: rtl/adder_byte_sequencer.sv
// Drives the 16-bit adder from a byte stream and returns the sum as two bytes.
module adder_byte_sequencer
    import adder_byte_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_ADD_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    adder_byte_sequencer_if.master bus
);

    state_t      state, nxt;
    logic [7:0]  timer;
    logic [15:0] sum_q;
    logic        cout_q;
    logic        err_q;
    logic        load, full, capture, abort;

    assign load = bus.in_valid && (state == LOAD);

    adder_byte_sequencer_operand_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .clr     (state == RELEASE),
        .data    (bus.in_data),
        .cin     (bus.in_cin),
        .full    (full),
        .add_A   (bus.add_A),
        .add_B   (bus.add_B),
        .add_cin (bus.add_cin)
    );

    always_comb begin
        nxt     = state;
        capture = 1'b0;
        abort   = 1'b0;
        case (state)
            LOAD:    if (full) nxt = ISSUE;
            // timer==0 is the guard cycle: a stale ready from the adder is not trusted.
            ISSUE: begin
                if (timer != 8'd0 && bus.add_ready) begin
                    capture = 1'b1;
                    nxt     = SEND_LO;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    abort = 1'b1;
                    nxt   = RELEASE;
                end
            end
            SEND_LO: if (bus.out_ready) nxt = SEND_HI;
            SEND_HI: if (bus.out_ready) nxt = RELEASE;
            RELEASE: if (!bus.add_ready) nxt = LOAD;
            default: nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= LOAD;
            timer  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= nxt;
            timer <= (state == ISSUE) ? timer + 8'd1 : 8'd0;
            err_q <= abort;
            if (capture) begin
                sum_q  <= bus.add_sum;
                cout_q <= bus.add_cout;
            end
        end
    end

    // Outputs decode straight from state so an async reset drops add_en at once.
    always_comb begin
        bus.out_data = 8'd0;
        case (state)
            SEND_LO: bus.out_data = sum_q[7:0];
            SEND_HI: bus.out_data = sum_q[15:8];
            default: bus.out_data = 8'd0;
        endcase
    end

    assign bus.in_ready    = (state == LOAD);
    assign bus.add_en      = (state == ISSUE);
    assign bus.out_valid   = (state == SEND_LO) || (state == SEND_HI);
    assign bus.out_last    = (state == SEND_HI);
    assign bus.out_cout    = cout_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_adder_byte_sequencer.sv
// Directed bench: scoreboard queue filled by stimulus, drained by an output monitor.
module tb_adder_byte_sequencer;
    import adder_byte_sequencer_pkg::*;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
        logic       cout;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adder_byte_sequencer_if bus();

    adder_byte_sequencer #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    int lat     = 3;
    bit never   = 1'b0;
    int acnt    = 0;
    int en_cnt  = 0;
    int err_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Adder model: ready after `lat` enabled cycles, drops whenever en is low.
    always @(negedge clk) begin
        if (bus.add_en) begin
            acnt++;
            if (!never && acnt >= lat) begin
                bus.add_ready = 1'b1;
                {bus.add_cout, bus.add_sum} = 17'(bus.add_A) + 17'(bus.add_B) + 17'(bus.add_cin);
            end
        end else begin
            acnt          = 0;
            bus.add_ready = 1'b0;
        end
        if (bus.add_en)      en_cnt++;
        if (bus.err_timeout) err_cnt++;
    end

    // Monitor: every accepted output byte is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got byte %0h want none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
                chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
                chk("out_cout", {31'd0, bus.out_cout}, {31'd0, e.cout});
            end
        end
    end

    task automatic send_byte(logic [7:0] d, logic c);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_cin   = c;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 100);
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Carry-in is driven inverted on the first three bytes to prove it is taken with B_hi.
    task automatic load_op(logic [15:0] a, logic [15:0] b, logic c);
        send_byte(a[7:0],  ~c);
        send_byte(a[15:8], ~c);
        send_byte(b[7:0],  ~c);
        chk("add_en_before", {31'd0, bus.add_en}, 32'd0);
        send_byte(b[15:8], c);
        chk("add_en_after", {31'd0, bus.add_en}, 32'd1);
        chk("add_A", {16'd0, bus.add_A}, {16'd0, a});
        chk("add_B", {16'd0, bus.add_B}, {16'd0, b});
        chk("add_cin", {31'd0, bus.add_cin}, {31'd0, c});
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(logic [7:0] lo, logic [7:0] hi, logic c);
        exp_q.push_back('{last: 1'b0, data: lo, cout: c});
        exp_q.push_back('{last: 1'b1, data: hi, cout: c});
    endtask

    initial begin
        int t;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        bus.add_ready = 1'b0;
        bus.add_sum   = 16'd0;
        bus.add_cout  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_add_en",    {31'd0, bus.add_en},    32'd0);
        chk("rst_add_A",     {16'd0, bus.add_A},     32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, bus.out_data},  32'd0);
        chk("rst_out_cout",  {31'd0, bus.out_cout},  32'd0);
        chk("rst_err",       {31'd0, bus.err_timeout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        push_exp(8'hFE, 8'h00, 1'b0);
        load_op(16'h007F, 16'h007F, 1'b0);
        wait_idle();

        push_exp(8'h00, 8'h00, 1'b1);
        load_op(16'hFFFF, 16'h0001, 1'b0);
        wait_idle();

        push_exp(8'h36, 8'h12, 1'b0);
        load_op(16'h1234, 16'h0001, 1'b1);
        wait_idle();

        // Adder never answers: abort after 8 ISSUE cycles.
        never   = 1'b1;
        en_cnt  = 0;
        err_cnt = 0;
        load_op(16'h0005, 16'h0006, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("timeout_en_cycles", en_cnt, 32'd8);
        chk("timeout_err_pulses", err_cnt, 32'd1);
        chk("timeout_add_en", {31'd0, bus.add_en}, 32'd0);
        chk("timeout_in_ready", {31'd0, bus.in_ready}, 32'd1);
        never = 1'b0;

        // Consumer stalls on the low byte for 5 cycles.
        bus.out_ready = 1'b0;
        push_exp(8'hFE, 8'h00, 1'b0);
        load_op(16'h007F, 16'h007F, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("stall_reached", {31'd0, bus.out_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_data",  {24'd0, bus.out_data},  32'hFE);
            chk("stall_last",  {31'd0, bus.out_last},  32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of ISSUE.
        never = 1'b1;
        load_op(16'h1111, 16'h2222, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_add_en",   {31'd0, bus.add_en},    32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready},  32'd1);
        chk("midrst_add_A",    {16'd0, bus.add_A},     32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        never = 1'b0;
        @(posedge clk);
        #1;
        push_exp(8'h03, 8'h00, 1'b0);
        load_op(16'h0001, 16'h0002, 1'b0);
        wait_idle();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_byte_sequencer.md
Name: adder_byte_sequencer

Overview:
- Front-end/back-end stage wrapped around the 16-bit ripple/CLA adder in the 8-bit computer.
- Assembles 16-bit operands A and B from four bytes on the 8-bit data path and drives the adder's en/A/B/c_in.
- Waits for the adder's ready, captures the sum and carry, then returns the result as two bytes to the 8-bit path.

Parameters:
- TIMEOUT, 64: max cycles add_en stays high waiting for add_ready before abort; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input byte present
- in_data  in  8  operand byte; order A_lo, A_hi, B_lo, B_hi
- in_cin  in  1  carry-in; sampled with the B_hi byte
- in_ready  out  1  block accepts a byte this cycle
- add_en  out  1  adder enable
- add_A  out  16  operand A to adder
- add_B  out  16  operand B to adder
- add_cin  out  1  carry-in to adder
- add_ready  in  1  adder result valid
- add_sum  in  16  adder Output
- add_cout  in  1  adder c_out
- out_valid  out  1  result byte present
- out_data  out  8  result byte; sum_lo then sum_hi
- out_last  out  1  high with sum_hi
- out_cout  out  1  captured carry-out; held stable while out_valid is high
- out_ready  in  1  consumer accepts the byte
- err_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async assert, release is sync to clk): state=LOAD, byte_cnt=0, in_ready=1, add_en=0, add_A/add_B/add_cin=0, out_valid=0, out_data=0, out_last=0, out_cout=0, err_timeout=0, timer=0.
- Byte transfers occur on a rising edge when valid&&ready.
- LOAD:
  - in_ready=1.
  - Each accepted byte goes to slot byte_cnt; byte_cnt increments.
  - On the 4th byte, latch in_cin and go to ISSUE. add_en rises the cycle after the 4th transfer (latency 1).
- ISSUE:
  - in_ready=0, add_en=1; add_A/B/cin are stable for the whole state.
  - add_ready is ignored in the first ISSUE cycle (guard against a stale ready).
  - From the 2nd cycle, add_ready=1 captures add_sum and add_cout, then go to SEND_LO.
  - timer counts ISSUE cycles. If timer reaches TIMEOUT with no ready: pulse err_timeout, discard the operation, go to RELEASE.
- SEND_LO:
  - add_en=0, out_valid=1, out_data=sum[7:0], out_last=0.
  - On transfer, go to SEND_HI.
- SEND_HI:
  - out_valid=1, out_data=sum[15:8], out_last=1.
  - On transfer, go to RELEASE.
  - out_valid is held while out_ready=0; out_data is stable during the stall.
- RELEASE:
  - add_en=0, in_ready=0.
  - Stay until add_ready=0 (minimum 1 cycle), so the adder is re-armed.
  - Then go to LOAD with byte_cnt=0 and timer=0.
- Arithmetic: none internally. The result is exactly {add_cout, add_sum} as captured; no width extension.
- in_valid while not in LOAD: ignored; the upstream holds its byte.
- reset during ISSUE: add_en drops immediately (async); any partial operands are discarded.
- add_ready already high on entry to ISSUE: not sampled in the guard cycle. If it remains high in cycle 2 it is accepted; the adder contract guarantees ready drops while en was low in RELEASE.
- Back-to-back operations: minimum spacing is 4 load + 2 issue + 2 send + 1 release = 9 cycles.

Decomposition:
- Shared package (alu_pkg):
  - state encoding localparams LOAD/ISSUE/SEND_LO/SEND_HI/RELEASE
  - BYTES_PER_OP=4
  - DEFAULT_ADD_TIMEOUT=64
- One sub-module, operand_assembler: byte_cnt, the four byte registers and cin latch. Outputs full flag, add_A, add_B, add_cin.
- The FSM, timer and output path stay in adder_byte_sequencer.

Test Plan:
- Load 0x7F,0x00,0x7F,0x00, cin=0; adder model with ready after 3 cycles -> add_A=add_B=0x007F, add_en 1 cycle after 4th byte; output bytes 0xFE then 0x00 (out_last), out_cout=0.
- Load A=0xFFFF, B=0x0001, cin=0 -> out bytes 0x00,0x00, out_cout=1.
- Load A=0x1234, B=0x0001, cin=1 -> add_cin=1; out bytes 0x36,0x12, out_cout=0.
- Adder model never raises ready, TIMEOUT=8 -> err_timeout pulses exactly once after 8 ISSUE cycles; add_en drops; no out_valid; next load is accepted.
- out_ready held low 5 cycles during SEND_LO -> out_valid=1 and out_data=0xFE stable; no byte lost; sum_hi follows on release.
- Assert reset mid-ISSUE (add_en=1) -> add_en=0 same cycle. After release, reload 0x01,0x00,0x02,0x00 -> result 0x03,0x00.
